// File: rtl/id_ex_stage_pkg.sv
// Shared widths, FSM state encoding and helpers for the ID/EX pipeline stage.
// The optional load-use bubble counter is enabled with the STALL_CNT_EN macro.
package id_ex_stage_pkg;

  localparam int DSIZE_DEF  = 16;
  localparam int ASIZE_DEF  = 4;
  localparam int OPSIZE_DEF = 4;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  // Saturating increment so the bubble counter sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/id_ex_stage_lu_hazard.sv
// Load-use hazard compare: a held load whose rd feeds a source of the decoding instruction.
// Register 0 is hardwired to zero and never creates a dependency.
module lu_hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             ex_valid,
  input  logic             ex_memrd,
  input  logic [ASIZE-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [ASIZE-1:0] id_rs1,
  input  logic [ASIZE-1:0] id_rs2,
  output logic             lu_hazard
);

  assign lu_hazard = ex_valid & ex_memrd & (ex_rd != '0) & id_valid &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, load-use bubble, flush and WB operand patching.
// Define STALL_CNT_EN to build the saturating load-use bubble counter on stall_cnt.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DSIZE  = DSIZE_DEF,
  parameter int ASIZE  = ASIZE_DEF,
  parameter int OPSIZE = OPSIZE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [OPSIZE-1:0] id_op,
  input  logic [ASIZE-1:0]  id_rs1,
  input  logic [ASIZE-1:0]  id_rs2,
  input  logic [ASIZE-1:0]  id_rd,
  input  logic [DSIZE-1:0]  id_rdata1,
  input  logic [DSIZE-1:0]  id_rdata2,
  input  logic [DSIZE-1:0]  id_imm,
  input  logic              id_wen,
  input  logic              id_memrd,
  input  logic              flush,
  input  logic              wb_wen,
  input  logic [ASIZE-1:0]  wb_waddr,
  input  logic [DSIZE-1:0]  wb_wdata,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [OPSIZE-1:0] ex_op,
  output logic [ASIZE-1:0]  ex_rs1,
  output logic [ASIZE-1:0]  ex_rs2,
  output logic [ASIZE-1:0]  ex_rd,
  output logic [DSIZE-1:0]  ex_rdata1,
  output logic [DSIZE-1:0]  ex_rdata2,
  output logic [DSIZE-1:0]  ex_imm,
  output logic              ex_wen,
  output logic              ex_memrd,
  output logic [15:0]       stall_cnt
);

  state_t state;
  logic   lu_hazard;
  logic   hold;
  logic   patch1;
  logic   patch2;

  lu_hazard_detect #(.ASIZE(ASIZE)) u_lu_hazard (
    .ex_valid  (ex_valid),
    .ex_memrd  (ex_memrd),
    .ex_rd     (ex_rd),
    .id_valid  (id_valid),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .lu_hazard (lu_hazard)
  );

  assign id_ready = rst & ~flush & ~lu_hazard & (~ex_valid | ex_ready);
  assign hold     = (state == ST_FULL) & ~ex_ready;

  // A held instruction read its operands before the WB write landed; refresh them here.
  assign patch1 = wb_wen & (wb_waddr != '0) & (wb_waddr == ex_rs1);
  assign patch2 = wb_wen & (wb_waddr != '0) & (wb_waddr == ex_rs2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      ex_valid  <= 1'b0;
      ex_op     <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_wen    <= 1'b0;
      ex_memrd  <= 1'b0;
    end else if (flush) begin
      state    <= ST_EMPTY;
      ex_valid <= 1'b0;
      ex_wen   <= 1'b0;
      ex_memrd <= 1'b0;
    end else if (hold) begin
      if (patch1) ex_rdata1 <= wb_wdata;
      if (patch2) ex_rdata2 <= wb_wdata;
    end else if (lu_hazard) begin
      state    <= ST_BUBBLE;
      ex_valid <= 1'b0;
      ex_wen   <= 1'b0;
      ex_memrd <= 1'b0;
    end else if (id_valid && id_ready) begin
      state     <= ST_FULL;
      ex_valid  <= 1'b1;
      ex_op     <= id_op;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_rdata1 <= id_rdata1;
      ex_rdata2 <= id_rdata2;
      ex_imm    <= id_imm;
      ex_wen    <= id_wen;
      ex_memrd  <= id_memrd;
    end else begin
      state    <= ST_EMPTY;
      ex_valid <= 1'b0;
      ex_wen   <= 1'b0;
      ex_memrd <= 1'b0;
    end
  end

`ifdef STALL_CNT_EN
  logic        enter_bubble;
  logic [15:0] stall_q;

  assign enter_bubble = ~flush & ~hold & lu_hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (enter_bubble) begin
      stall_q <= sat_inc16(stall_q);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expected EX entries, a monitor pops on each EX transfer.
// Expected stall_cnt follows the STALL_CNT_EN macro.
module tb_id_ex_stage;

`ifdef STALL_CNT_EN
  localparam int EXP_STALL = 1;
`else
  localparam int EXP_STALL = 0;
`endif

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [15:0] rdata1;
    logic [15:0] rdata2;
    logic [15:0] imm;
    logic        wen;
    logic        memrd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [3:0]  id_op;
  logic [3:0]  id_rs1;
  logic [3:0]  id_rs2;
  logic [3:0]  id_rd;
  logic [15:0] id_rdata1;
  logic [15:0] id_rdata2;
  logic [15:0] id_imm;
  logic        id_wen;
  logic        id_memrd;
  logic        flush;
  logic        wb_wen;
  logic [3:0]  wb_waddr;
  logic [15:0] wb_wdata;
  logic        ex_ready;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [3:0]  ex_rs1;
  logic [3:0]  ex_rs2;
  logic [3:0]  ex_rd;
  logic [15:0] ex_rdata1;
  logic [15:0] ex_rdata2;
  logic [15:0] ex_imm;
  logic        ex_wen;
  logic        ex_memrd;
  logic [15:0] stall_cnt;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  id_ex_stage dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_op     (id_op),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_rd     (id_rd),
    .id_rdata1 (id_rdata1),
    .id_rdata2 (id_rdata2),
    .id_imm    (id_imm),
    .id_wen    (id_wen),
    .id_memrd  (id_memrd),
    .flush     (flush),
    .wb_wen    (wb_wen),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .ex_ready  (ex_ready),
    .ex_valid  (ex_valid),
    .ex_op     (ex_op),
    .ex_rs1    (ex_rs1),
    .ex_rs2    (ex_rs2),
    .ex_rd     (ex_rd),
    .ex_rdata1 (ex_rdata1),
    .ex_rdata2 (ex_rdata2),
    .ex_imm    (ex_imm),
    .ex_wen    (ex_wen),
    .ex_memrd  (ex_memrd),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Each EX handshake (valid & ready) must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t act;
    exp_t want;
    if (rst && ex_valid && ex_ready) begin
      act = '{ex_op, ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_wen, ex_memrd};
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL ex_transfer: got unexpected entry %h, required none", act);
      end else begin
        want = sb_q.pop_front();
        if (act !== want) begin
          bad++;
          $display("[TB] FAIL ex_transfer: got %h required %h", act, want);
        end
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                                input logic [3:0] rd, input logic [15:0] r1, input logic [15:0] r2,
                                input logic [15:0] imm, input logic wen, input logic memrd);
    id_valid  = 1'b1;
    id_op     = op;
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
    id_rdata1 = r1;
    id_rdata2 = r2;
    id_imm    = imm;
    id_wen    = wen;
    id_memrd  = memrd;
  endtask

  function automatic exp_t make_exp(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                                    input logic [3:0] rd, input logic [15:0] r1, input logic [15:0] r2,
                                    input logic [15:0] imm, input logic wen, input logic memrd);
    return '{op, rs1, rs2, rd, r1, r2, imm, wen, memrd};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; id_valid = 1'b0; id_op = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rdata1 = '0; id_rdata2 = '0; id_imm = '0; id_wen = 1'b0; id_memrd = 1'b0;
    flush = 1'b0; wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0; ex_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset ex_valid", int'(ex_valid), 0);
    check_output("reset id_ready", int'(id_ready), 0);
    check_output("reset stall_cnt", int'(stall_cnt), 0);
    rst = 1'b1;

    // Basic flow: one-cycle ID->EX latency
    apply_stimulus(4'h2, 4'd1, 4'd2, 4'd5, 16'd5, 16'd1, 16'd7, 1'b1, 1'b0);
    @(negedge clk);
    check_output("flow id_ready", int'(id_ready), 1);
    sb_q.push_back(make_exp(4'h2, 4'd1, 4'd2, 4'd5, 16'd5, 16'd1, 16'd7, 1'b1, 1'b0));
    next_cycle();
    id_valid = 1'b0;
    @(negedge clk);
    check_output("flow ex_valid", int'(ex_valid), 1);
    check_output("flow ex_rdata1", int'(ex_rdata1), 5);
    check_output("flow ex_rdata2", int'(ex_rdata2), 1);
    next_cycle();

    // Load-use: held load rd=4, next instruction reads r4
    apply_stimulus(4'h1, 4'd0, 4'd0, 4'd4, 16'd0, 16'd0, 16'd8, 1'b1, 1'b1);
    @(negedge clk);
    sb_q.push_back(make_exp(4'h1, 4'd0, 4'd0, 4'd4, 16'd0, 16'd0, 16'd8, 1'b1, 1'b1));
    next_cycle();
    apply_stimulus(4'h3, 4'd4, 4'd6, 4'd7, 16'd11, 16'd12, 16'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_output("loaduse id_ready", int'(id_ready), 0);
    next_cycle();
    @(negedge clk);
    check_output("bubble ex_valid", int'(ex_valid), 0);
    check_output("bubble ex_wen", int'(ex_wen), 0);
    check_output("bubble id_ready", int'(id_ready), 1);
    check_output("bubble stall_cnt", int'(stall_cnt), EXP_STALL);
    sb_q.push_back(make_exp(4'h3, 4'd4, 4'd6, 4'd7, 16'd11, 16'd12, 16'd0, 1'b1, 1'b0));
    next_cycle();
    id_valid = 1'b0;
    @(negedge clk);
    check_output("after bubble ex_valid", int'(ex_valid), 1);
    next_cycle();

    // Stall patch: held rs1=3, rs2=0 while EX is not ready
    apply_stimulus(4'h4, 4'd3, 4'd0, 4'd1, 16'd0, 16'd2, 16'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_output("patch id_ready", int'(id_ready), 1);
    sb_q.push_back(make_exp(4'h4, 4'd3, 4'd0, 4'd1, 16'd36, 16'd2, 16'd0, 1'b1, 1'b0));
    next_cycle();
    id_valid = 1'b0; ex_ready = 1'b0;
    wb_wen = 1'b1; wb_waddr = 4'd3; wb_wdata = 16'd36;
    @(negedge clk);
    check_output("stalled id_ready", int'(id_ready), 0);
    next_cycle();
    wb_waddr = 4'd0; wb_wdata = 16'd99;
    @(negedge clk);
    check_output("patch ex_rdata1", int'(ex_rdata1), 36);
    next_cycle();
    wb_wen = 1'b0; wb_waddr = 4'd3; wb_wdata = 16'd77;
    @(negedge clk);
    check_output("r0 nopatch ex_rdata1", int'(ex_rdata1), 36);
    check_output("r0 nopatch ex_rdata2", int'(ex_rdata2), 2);
    next_cycle();
    ex_ready = 1'b1;
    @(negedge clk);
    check_output("wen off ex_rdata1", int'(ex_rdata1), 36);
    next_cycle();

    // Flush beats both the stall and the load-use hazard
    apply_stimulus(4'h5, 4'd1, 4'd2, 4'd5, 16'd3, 16'd4, 16'd0, 1'b1, 1'b1);
    @(negedge clk);
    next_cycle();
    ex_ready = 1'b0;
    apply_stimulus(4'h6, 4'd5, 4'd0, 4'd2, 16'd1, 16'd1, 16'd0, 1'b1, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check_output("flush id_ready", int'(id_ready), 0);
    next_cycle();
    flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    check_output("flush ex_valid", int'(ex_valid), 0);
    check_output("flush ex_memrd", int'(ex_memrd), 0);
    check_output("flush stall_cnt", int'(stall_cnt), EXP_STALL);
    next_cycle();

    // Load to r0 never stalls a reader of r0
    apply_stimulus(4'h7, 4'd1, 4'd2, 4'd0, 16'd21, 16'd22, 16'd3, 1'b1, 1'b1);
    @(negedge clk);
    sb_q.push_back(make_exp(4'h7, 4'd1, 4'd2, 4'd0, 16'd21, 16'd22, 16'd3, 1'b1, 1'b1));
    next_cycle();
    apply_stimulus(4'h8, 4'd0, 4'd0, 4'd2, 16'd0, 16'd0, 16'd5, 1'b1, 1'b0);
    @(negedge clk);
    check_output("r0 id_ready", int'(id_ready), 1);
    sb_q.push_back(make_exp(4'h8, 4'd0, 4'd0, 4'd2, 16'd0, 16'd0, 16'd5, 1'b1, 1'b0));
    next_cycle();
    id_valid = 1'b0;
    @(negedge clk);
    check_output("r0 ex_valid", int'(ex_valid), 1);
    check_output("r0 stall_cnt", int'(stall_cnt), EXP_STALL);
    next_cycle();

    // Asynchronous reset while an instruction is held
    ex_ready = 1'b0;
    apply_stimulus(4'h9, 4'd1, 4'd1, 4'd3, 16'd40, 16'd41, 16'd0, 1'b1, 1'b0);
    @(negedge clk);
    next_cycle();
    #1;
    check_output("pre-reset ex_valid", int'(ex_valid), 1);
    #1;
    rst = 1'b0; ex_ready = 1'b1;
    #1;
    check_output("async ex_valid", int'(ex_valid), 0);
    check_output("async ex_op", int'(ex_op), 0);
    check_output("async ex_rdata1", int'(ex_rdata1), 0);
    check_output("async ex_wen", int'(ex_wen), 0);
    check_output("async id_ready", int'(id_ready), 0);
    check_output("async stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    check_output("in-reset id_ready", int'(id_ready), 0);
    next_cycle();
    rst = 1'b1; id_valid = 1'b0;
    @(negedge clk);
    check_output("post-reset id_ready", int'(id_ready), 1);
    next_cycle();

    check_output("scoreboard drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
